// File: rtl/rast_stream_pkg.sv
// rast_stream_pkg: shared helpers for rasterizer stream buffering.
package rast_stream_pkg;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/axi_stream_fifo_if.sv
// axi_stream_fifo_if: upstream/downstream handshake, flush and fill status of the stream fifo.
interface axi_stream_fifo_if #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 5
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic             flush;
  logic             vld_in;
  logic             rdy_in;
  logic [WIDTH-1:0] data_in;
  logic             vld_out;
  logic             rdy_out;
  logic [WIDTH-1:0] data_out;
  logic [CNT_W-1:0] count;
  logic             almost_full;
  logic             almost_empty;
  modport master (
    output flush, vld_in, data_in, rdy_out,
    input  rdy_in, vld_out, data_out, count, almost_full, almost_empty
  );
  modport slave (
    input  flush, vld_in, data_in, rdy_out,
    output rdy_in, vld_out, data_out, count, almost_full, almost_empty
  );
endinterface

// File: rtl/fifo_wrap_ctr.sv
// fifo_wrap_ctr: modulo-DEPTH counter with compare-based wrap, so any DEPTH works.
module fifo_wrap_ctr
  import rast_stream_pkg::*;
#(
  parameter int DEPTH = 5,
  parameter int W = clog2_min1(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (clr) q <= '0;
    else if (inc) q <= W'(next_ptr(int'(q), DEPTH));
endmodule

// File: rtl/axi_stream_fifo.sv
// axi_stream_fifo: first-word-fall-through valid/ready fifo with exact fill level,
// registered almost-full/almost-empty flags and synchronous flush.
module axi_stream_fifo
  import rast_stream_pkg::*;
#(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 5,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1
) (
  input logic clk,
  input logic rst_n,
  axi_stream_fifo_if.slave s
);
  localparam int PTR_W = clog2_min1(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic af, ae, push, pop;
  // Handshake readiness comes only from the registered count: no input-to-output paths.
  assign s.rdy_in       = cnt < CNT_W'(DEPTH);
  assign s.vld_out      = cnt != '0;
  assign s.data_out     = mem[rd_ptr];
  assign s.count        = cnt;
  assign s.almost_full  = af;
  assign s.almost_empty = ae;
  assign push = s.vld_in & s.rdy_in;
  assign pop  = s.vld_out & s.rdy_out;
  always_comb
    cnt_nxt = s.flush ? '0
            : (push & ~pop) ? cnt + CNT_W'(1)
            : (pop & ~push) ? cnt - CNT_W'(1)
            : cnt;
  fifo_wrap_ctr #(.DEPTH(DEPTH), .W(PTR_W)) u_wr (
    .clk(clk), .rst_n(rst_n), .inc(push), .clr(s.flush), .q(wr_ptr)
  );
  fifo_wrap_ctr #(.DEPTH(DEPTH), .W(PTR_W)) u_rd (
    .clk(clk), .rst_n(rst_n), .inc(pop), .clr(s.flush), .q(rd_ptr)
  );
  always_ff @(posedge clk)
    if (push && !s.flush) mem[wr_ptr] <= s.data_in;
  // Flags are registered from the next count so they line up with count every cycle.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      af  <= 1'b0;
      ae  <= 1'b1;
    end else begin
      cnt <= cnt_nxt;
      af  <= cnt_nxt >= CNT_W'(AF_LEVEL);
      ae  <= cnt_nxt <= CNT_W'(AE_LEVEL);
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) cnt <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_axi_stream_fifo.sv
// tb_axi_stream_fifo: directed and random stimulus checked every cycle against a queue model.
module tb_axi_stream_fifo;
  localparam int W = 16, D = 5, AF = 3, AE = 1;
  logic clk = 0, rst_n = 0;
  int checks = 0, errors = 0;
  logic [W-1:0] q[$];
  axi_stream_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
  axi_stream_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .rst_n(rst_n), .s(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: a plain queue, updated from the inputs and its own occupancy.
  always @(negedge rst_n) q.delete();
  always @(posedge clk) begin
    bit pu, po;
    if (rst_n) begin
      pu = bus.vld_in && q.size() < D;
      po = bus.rdy_out && q.size() > 0;
      if (bus.flush) q.delete();
      else begin
        if (po) void'(q.pop_front());
        if (pu) q.push_back(bus.data_in);
      end
    end
  end
  always @(negedge clk) begin
    chk("count", 64'(bus.count), 64'(q.size()));
    chk("vld_out", 64'(bus.vld_out), 64'(q.size() != 0));
    chk("rdy_in", 64'(bus.rdy_in), 64'(q.size() < D));
    chk("almost_full", 64'(bus.almost_full), 64'(q.size() >= AF));
    chk("almost_empty", 64'(bus.almost_empty), 64'(q.size() <= AE));
    if (q.size() != 0) chk("data_out", 64'(bus.data_out), 64'(q[0]));
  end
  task automatic step(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bus.vld_in = v; bus.data_in = d; bus.rdy_out = r; bus.flush = f;
    @(posedge clk); #1;
  endtask
  initial begin
    bus.vld_in = 0; bus.data_in = '0; bus.rdy_out = 0; bus.flush = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_vld", 64'(bus.vld_out), 0);
    chk("rst_rdy", 64'(bus.rdy_in), 1);
    chk("rst_af", 64'(bus.almost_full), 0);
    chk("rst_ae", 64'(bus.almost_empty), 1);
    chk("rst_cnt", 64'(bus.count), 0);
    rst_n = 1;
    step(1, 16'hA5, 0, 0);
    chk("t1_vld", 64'(bus.vld_out), 1);
    chk("t1_data", 64'(bus.data_out), 64'hA5);
    chk("t1_cnt", 64'(bus.count), 1);
    chk("t1_ae", 64'(bus.almost_empty), 1);
    step(0, 0, 1, 0);
    for (int i = 1; i <= 5; i++) step(1, W'(i), 0, 0);
    chk("t2_rdy", 64'(bus.rdy_in), 0);
    chk("t2_cnt", 64'(bus.count), 5);
    step(1, 16'd6, 0, 0);
    chk("t2_cnt6", 64'(bus.count), 5);
    for (int i = 1; i <= 5; i++) begin
      chk("t2_drain", 64'(bus.data_out), 64'(i));
      step(0, 0, 1, 0);
    end
    chk("t2_empty", 64'(bus.vld_out), 0);
    step(1, 16'd100, 0, 0);
    step(1, 16'd101, 0, 0);
    for (int k = 0; k < 13; k++) begin
      chk("t3_head", 64'(bus.data_out), 64'(100 + k));
      step(1, W'(102 + k), 1, 0);
    end
    chk("t3_cnt", 64'(bus.count), 2);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, W'(40 + i), 0, 0);
    step(1, 16'd50, 1, 0);
    chk("t4_pop_only", 64'(bus.count), 4);
    step(1, 16'd50, 0, 0);
    chk("t4_push_next", 64'(bus.count), 5);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("t4_last", 64'(bus.data_out), 64'd50);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, W'(60 + i), 0, 0);
    chk("t5_af", 64'(bus.almost_full), 1);
    chk("t5_ae", 64'(bus.almost_empty), 0);
    step(1, 16'd77, 0, 1);
    chk("t5_cnt", 64'(bus.count), 0);
    chk("t5_vld", 64'(bus.vld_out), 0);
    chk("t5_ae0", 64'(bus.almost_empty), 1);
    step(1, 16'd88, 0, 0);
    chk("t5_after", 64'(bus.data_out), 64'd88);
    for (int i = 0; i < 2; i++) step(1, W'(20 + i), 0, 0);
    bus.vld_in = 0; bus.rdy_out = 0;
    #1 rst_n = 0;
    #1;
    chk("t6_vld", 64'(bus.vld_out), 0);
    chk("t6_cnt", 64'(bus.count), 0);
    @(posedge clk); #1 rst_n = 1;
    step(1, 16'h33, 0, 0);
    chk("t6_first", 64'(bus.data_out), 64'h33);
    chk("t6_cnt1", 64'(bus.count), 1);
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 2) == 0 || i > 500),
           1'($urandom_range(0, 39) == 0));
    step(0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
